// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to instruction
// memory, buffers returned words in an in-order FIFO and presents the head
// word with its PC on a valid/ready interface.
// Reads are issued only while buffered words plus in-flight reads stay below
// FIFO_DEPTH, so every returning word is guaranteed a buffer slot.
// A redirect empties the buffer. Reads still in flight at that point are
// counted in a discard counter and dropped when their data returns.
// Optional feature: define IF_MISALIGN_CHECK_EN to add the misalign output.
// A redirect to a non-word-aligned PC then stops fetching until an aligned
// redirect or reset.
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    localparam int          AW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] discard_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] pcq_rd_r;
    logic [AW-1:0] pcq_wr_r;
    logic [31:0]   data_mem_r [FIFO_DEPTH];
    logic [31:0]   pc_mem_r   [FIFO_DEPTH];
    logic [31:0]   pcq_r      [FIFO_DEPTH];
    logic          misalign_r;

    logic [CW:0]   credit_sum_s;
    logic          req_block_s;
    logic          grant_s;
    logic          keep_s;
    logic          head_valid_s;
    logic          pop_s;

    // Request credit, handshakes and head-of-FIFO presentation
    always_comb begin
        credit_sum_s = {1'b0, count_r} + {1'b0, outstanding_r};
`ifdef IF_MISALIGN_CHECK_EN
        req_block_s  = misalign_r;
`else
        req_block_s  = 1'b0;
`endif
        mem_req      = !rst && !redirect && !req_block_s &&
                       (credit_sum_s < (CW+1)'(FIFO_DEPTH));
        mem_addr     = pc_r;
        grant_s      = mem_req && mem_gnt;
        keep_s       = mem_rvalid && (discard_r == {CW{1'b0}});
        head_valid_s = (count_r != {CW{1'b0}}) && !req_block_s;
        pop_s        = head_valid_s && inst_ready;
        inst_valid   = head_valid_s;
        if (head_valid_s) begin
            inst    = data_mem_r[rd_ptr_r];
            inst_pc = pc_mem_r[rd_ptr_r];
        end else begin
            inst    = NOP;
            inst_pc = 32'h0000_0000;
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    assign misalign = misalign_r;
`endif

    // PC, occupancy counters and queue pointers; redirect outranks everything but reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            count_r       <= {CW{1'b0}};
            outstanding_r <= {CW{1'b0}};
            discard_r     <= {CW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            pcq_rd_r      <= {AW{1'b0}};
            pcq_wr_r      <= {AW{1'b0}};
            misalign_r    <= 1'b0;
        end else if (redirect) begin
            pc_r          <= redirect_pc & 32'hFFFF_FFFC;
            count_r       <= {CW{1'b0}};
            outstanding_r <= outstanding_r - CW'(mem_rvalid);
            discard_r     <= outstanding_r - CW'(mem_rvalid);
            rd_ptr_r      <= {AW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            pcq_rd_r      <= {AW{1'b0}};
            pcq_wr_r      <= {AW{1'b0}};
`ifdef IF_MISALIGN_CHECK_EN
            misalign_r    <= |redirect_pc[1:0];
`else
            misalign_r    <= 1'b0;
`endif
        end else begin
            if (grant_s) begin
                pc_r     <= pc_r + 32'd4;
                pcq_wr_r <= pcq_wr_r + AW'(1'b1);
            end
            if (keep_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
                pcq_rd_r <= pcq_rd_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            if (mem_rvalid && (discard_r != {CW{1'b0}})) begin
                discard_r <= discard_r - CW'(1'b1);
            end
            count_r       <= count_r + CW'(keep_s) - CW'(pop_s);
            outstanding_r <= outstanding_r + CW'(grant_s) - CW'(mem_rvalid);
        end
    end

    // Storage: PC of each issued read, and the returned word paired with its PC
    always_ff @(posedge clk) begin
        if (grant_s) begin
            pcq_r[pcq_wr_r] <= pc_r;
        end
        if (keep_s) begin
            data_mem_r[wr_ptr_r] <= mem_rdata;
            pc_mem_r[wr_ptr_r]   <= pcq_r[pcq_rd_r];
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a memory model with programmable latency,
// a reference PC model and a scoreboard of words expected at the output.
// A second instance with RESET_PC near the top of memory checks address wrap.
module tb_if_fetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        b_req;
    logic [31:0] b_addr;
    logic        b_valid;
    logic [31:0] b_inst;
    logic [31:0] b_pc;
`ifdef IF_MISALIGN_CHECK_EN
    logic        misalign;
    logic        b_misalign;
    logic        exp_mis;
`endif

    mreq_t       mq[$];
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          last_due = 0;
    int          grant_cnt = 0;
    int          lat = 1;
    bit          rand_lat = 1'b0;
    int          gnt_mode = 0;
    logic [31:0] exp_pc;
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic        s_breq;
    logic [31:0] s_baddr;
    logic        got_first;
    logic [31:0] first_pop_pc;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
`ifdef IF_MISALIGN_CHECK_EN
        , .misalign(misalign)
`endif
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst),
        .mem_req(b_req), .mem_addr(b_addr), .mem_gnt(1'b1),
        .mem_rvalid(1'b0), .mem_rdata(32'h0000_0000),
        .redirect(1'b0), .redirect_pc(32'h0000_0000),
        .inst_valid(b_valid), .inst(b_inst), .inst_pc(b_pc),
        .inst_ready(1'b0)
`ifdef IF_MISALIGN_CHECK_EN
        , .misalign(b_misalign)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0000_0000;
        mem_rvalid = 1'b0; mem_gnt = 1'b0; inst_ready = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk); #1;
        check_eq("rst_req", mem_req, 1'b0);
        check_eq("rst_valid", inst_valid, 1'b0);
        check_eq("rst_inst", inst, NOP);
        check_eq("rst_pc", inst_pc, 32'h0000_0000);
`ifdef IF_MISALIGN_CHECK_EN
        check_eq("rst_misalign", misalign, 1'b0);
        exp_mis = 1'b0;
`endif
        mq.delete(); sb.delete();
        epoch++; last_due = cyc; grant_cnt = 0;
        exp_pc = 32'h0000_0000;
        got_first = 1'b0; first_pop_pc = 32'hFFFF_FFFF;
        rst = 1'b0;
    endtask

    // One clock cycle: drive memory, check outputs, advance the reference model
    task automatic tick();
        mreq_t r;
        exp_t  e;
        bit    rv;
        int    l;
        int    due;
        rv = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            rv = 1'b1;
            mem_rvalid = 1'b1;
            mem_rdata  = r.data;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        case (gnt_mode)
            0:       mem_gnt = 1'b1;
            1:       mem_gnt = 1'($urandom_range(0, 1));
            default: mem_gnt = 1'b0;
        endcase
        #1;
        s_req = mem_req; s_addr = mem_addr; s_valid = inst_valid;
        s_breq = b_req; s_baddr = b_addr;
        if (mem_req) check_eq("mem_addr", mem_addr, exp_pc);
        if (redirect) check_eq("req_during_redirect", mem_req, 1'b0);
        check_eq("inst_valid", inst_valid, sb.size() != 0);
`ifdef IF_MISALIGN_CHECK_EN
        check_eq("misalign", misalign, exp_mis);
        if (exp_mis) check_eq("req_while_misaligned", mem_req, 1'b0);
`endif
        if (!inst_valid) begin
            check_eq("idle_inst", inst, NOP);
            check_eq("idle_pc", inst_pc, 32'h0000_0000);
        end else if (inst_ready && !redirect) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("pop_inst", inst, e.data);
                check_eq("pop_pc", inst_pc, e.pc);
                if (!got_first) begin
                    got_first = 1'b1;
                    first_pop_pc = inst_pc;
                end
            end else begin
                check_eq("spurious_pop", inst_valid, 1'b0);
            end
        end
        if (mem_req && mem_gnt) begin
            l = rand_lat ? $urandom_range(1, 3) : lat;
            due = (cyc + l > last_due) ? cyc + l : last_due + 1;
            last_due = due;
            mq.push_back('{addr: mem_addr, data: $urandom, epoch: epoch, due: due});
            exp_pc = exp_pc + 32'd4;
            grant_cnt++;
        end
        if (rv && r.epoch == epoch && !redirect) sb.push_back('{data: r.data, pc: r.addr});
        if (redirect) begin
            sb.delete();
            epoch++;
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
            got_first = 1'b0;
            first_pop_pc = 32'hFFFF_FFFF;
`ifdef IF_MISALIGN_CHECK_EN
            exp_mis = |redirect_pc[1:0];
`endif
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect = 1'b1; redirect_pc = pc;
        tick();
        redirect = 1'b0;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0000_0000;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0000_0000; inst_ready = 1'b0;
        @(negedge clk);

        // 1 + 5: streaming at 1-cycle latency; wrap instance addresses
        do_reset();
        inst_ready = 1'b1; gnt_mode = 0; lat = 1; rand_lat = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq("t1_req", s_req, 1'b1);
            check_eq("t1_valid", s_valid, i >= 3);
            if (i == 1) check_eq("t5_addr0", s_baddr, 32'hFFFF_FFF8);
            if (i == 2) check_eq("t5_addr1", s_baddr, 32'hFFFF_FFFC);
            if (i == 3) check_eq("t5_addr2", s_baddr, 32'h0000_0000);
            if (i <= 3) check_eq("t5_req", s_breq, 1'b1);
        end
        check_eq("t1_first_pc", first_pop_pc, 32'h0000_0000);

        // 2: downstream stall fills exactly FIFO_DEPTH credits
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("t2_grants", grant_cnt, DEPTH);
        check_eq("t2_req_off", s_req, 1'b0);
        inst_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check_eq("t2_first_pc", first_pop_pc, 32'h0000_0000);

        // 3: redirect with two reads in flight
        do_reset();
        inst_ready = 1'b1; lat = 3;
        tick(); tick();
        check_eq("t3_inflight", mq.size(), 2);
        do_redirect(32'h0000_0100);
        tick();
        check_eq("t3_next_req", s_req, 1'b1);
        check_eq("t3_next_addr", s_addr, 32'h0000_0100);
        for (int i = 0; i < 12; i++) tick();
        check_eq("t3_first_pc", first_pop_pc, 32'h0000_0100);

        // 4: redirect coinciding with rvalid, then a second redirect
        do_reset();
        inst_ready = 1'b1; lat = 2;
        for (int i = 0; i < 5; i++) tick();
        do_redirect(32'h0000_0300);
        do_redirect(32'h0000_0200);
        for (int i = 0; i < 10; i++) tick();
        check_eq("t4_first_pc", first_pop_pc, 32'h0000_0200);

        // 6: misaligned redirect
        do_reset();
        inst_ready = 1'b1; lat = 1;
        tick(); tick(); tick();
        do_redirect(32'h0000_0102);
        tick();
`ifdef IF_MISALIGN_CHECK_EN
        check_eq("t6_misalign_set", misalign, 1'b1);
        check_eq("t6_req_off", s_req, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check_eq("t6_req_still_off", s_req, 1'b0);
        do_redirect(32'h0000_0104);
        tick();
        check_eq("t6_misalign_clr", misalign, 1'b0);
        check_eq("t6_resume_req", s_req, 1'b1);
        check_eq("t6_resume_addr", s_addr, 32'h0000_0104);
        for (int i = 0; i < 6; i++) tick();
        check_eq("t6_first_pc", first_pop_pc, 32'h0000_0104);
`else
        check_eq("t6_aligned_req", s_req, 1'b1);
        check_eq("t6_aligned_addr", s_addr, 32'h0000_0100);
        for (int i = 0; i < 6; i++) tick();
        check_eq("t6_first_pc", first_pop_pc, 32'h0000_0100);
`endif

        // Random traffic: random grants, latency, backpressure and redirects
        do_reset();
        gnt_mode = 1; rand_lat = 1'b1;
        for (int i = 0; i < 300; i++) begin
            inst_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                do_redirect($urandom & 32'hFFFF_FFFC);
            end else begin
                tick();
            end
        end
        gnt_mode = 2; inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_eq("drain_sb_empty", sb.size(), 0);
        check_eq("drain_valid", inst_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
